alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 60 ++++++
 rtl/alu_issue_stage_if.sv | 27 ++
 rtl/alu_issue_skid.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 93 +++++++++
 tb/tb_alu_issue_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared RV32I ALU encodings: ALU op codes, major opcodes, funct3/funct7 values,
// and the decoded issue bundle carried through the issue stage.
package alu_issue_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_t;

  localparam int ISSUE_W = $bits(issue_t);

  // alt selects the funct7=0100000 variant (SUB / SRA) where one exists.
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream instruction/operand handshake and downstream issued-op handshake.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  modport master (
    output in_valid, instr, pc, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, rd, rd_we, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, rd, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready skid buffer (output reg + skid reg); one cycle latency.
// in_rdy_o is registered (skid empty); output data holds while stalled.
module alu_issue_skid #(
  parameter int W = 75
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         out_vld_q, out_vld_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         out_free;
  logic         accept;

  assign out_free = !out_vld_q || out_rdy_i;
  assign accept   = in_vld_i && !skid_vld_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (out_free) begin
      // A full skid always has priority; upstream is blocked in that cycle anyway.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d = 1'b1;
        out_dat_d = in_dat_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign in_rdy_o  = !skid_vld_q;
  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue: combinational decode into a 2-entry skid; results one cycle after accept.
// in_ready drops only when the skid entry is occupied; outputs hold while out_ready is low.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave io
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_alt;
  logic        is_shift;
  logic        legal;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  issue_t      dec;
  issue_t      issued;
  logic        unused_rs1_field;

  assign opcode   = io.instr[6:0];
  assign f3       = io.instr[14:12];
  assign f7       = io.instr[31:25];
  assign is_alt   = (f7 == F7_ALT);
  assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  assign imm_i    = {{20{io.instr[31]}}, io.instr[31:20]};
  assign imm_u    = {io.instr[31:12], 12'h000};

  // Register numbers arrive pre-read as rs1_val/rs2_val; the rs1 field is not needed.
  assign unused_rs1_field = ^io.instr[19:15];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal      = (f7 == F7_BASE) || (is_alt && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
        dec.alu_op = f3_to_op(f3, is_alt);
        dec.alu_a  = io.rs1_val;
        dec.alu_b  = is_shift ? {27'd0, io.rs2_val[4:0]} : io.rs2_val;
      end
      OPC_OP_IMM: begin
        if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
        else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || is_alt;
        else                       legal = 1'b1;
        dec.alu_op = f3_to_op(f3, is_alt && (f3 == F3_SRL_SRA));
        dec.alu_a  = io.rs1_val;
        dec.alu_b  = is_shift ? {27'd0, io.instr[24:20]} : imm_i;
      end
      OPC_LUI: begin
        legal      = 1'b1;
        dec.alu_op = ALU_ADD;
        dec.alu_b  = imm_u;
      end
      OPC_AUIPC: begin
        legal      = 1'b1;
        dec.alu_op = ALU_ADD;
        dec.alu_a  = io.pc;
        dec.alu_b  = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.alu_op = ALU_ADD;
      dec.alu_a  = '0;
      dec.alu_b  = '0;
    end
    dec.rd      = io.instr[11:7];
    dec.rd_we   = legal && (io.instr[11:7] != 5'd0);
    dec.illegal = !legal;
  end

  alu_issue_skid #(.W(ISSUE_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (io.in_valid),
    .in_rdy_o  (io.in_ready),
    .in_dat_i  (dec),
    .out_vld_o (io.out_valid),
    .out_rdy_i (io.out_ready),
    .out_dat_o (issued)
  );

  assign io.alu_op  = issued.alu_op;
  assign io.alu_a   = issued.alu_a;
  assign io.alu_b   = issued.alu_b;
  assign io.rd      = issued.rd;
  assign io.rd_we   = issued.rd_we;
  assign io.illegal = issued.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode cases, backpressure, reset, randomized stream.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_issue_stage_if bus();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  issue_t got;
  always_comb got = {bus.alu_op, bus.alu_a, bus.alu_b, bus.rd, bus.rd_we, bus.illegal};

  // Reference decode straight from the ISA rules, using raw encodings.
  function automatic issue_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] r1, input logic [31:0] r2);
    issue_t      e;
    logic [31:0] op_tab;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        ok, shift;
    op_tab = 32'h98654320;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    e  = '0;
    ok = 1'b0;
    if (opc == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.alu_op = op_tab[{f3, 2'b00} +: 4];
      if (f7 == 7'h20) e.alu_op = (f3 == 3'd0) ? 4'd1 : 4'd7;
      e.alu_a = r1;
      e.alu_b = shift ? (r2 & 32'h1f) : r2;
    end else if (opc == 7'h13) begin
      ok = !shift || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
      e.alu_op = op_tab[{f3, 2'b00} +: 4];
      if (f3 == 3'd5 && f7 == 7'h20) e.alu_op = 4'd7;
      e.alu_a = r1;
      e.alu_b = shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
    end else if (opc == 7'h37 || opc == 7'h17) begin
      ok = 1'b1;
      e.alu_a = (opc == 7'h17) ? pcv : 32'd0;
      e.alu_b = {ins[31:12], 12'h000};
    end
    if (!ok) begin
      e.alu_op = 4'd0;
      e.alu_a  = 32'd0;
      e.alu_b  = 32'd0;
    end
    e.rd      = ins[11:7];
    e.rd_we   = ok && (ins[11:7] != 5'd0);
    e.illegal = !ok;
    return e;
  endfunction

  // Present one instruction with out_ready high; returns at the negedge after acceptance.
  task automatic issue_one(input logic [31:0] ins, input logic [31:0] pcv,
                           input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.instr     = ins;
    bus.pc        = pcv;
    bus.rs1_val   = r1;
    bus.rs2_val   = r2;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.instr     = 32'h0;
    bus.pc        = 32'h0;
    bus.rs1_val   = 32'h0;
    bus.rs2_val   = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", got); end
  endtask

  task automatic test_decode;
    issue_t exp;
    issue_one(32'h002081B3, 32'h100, 32'd5, 32'd7);
    exp = {4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    checks++;
    if (bus.out_valid !== 1'b1 || got !== exp) begin errors++; $display("FAIL add: got v=%b %h want %h", bus.out_valid, got, exp); end
    issue_one(32'h40335293, 32'h104, 32'h80000000, 32'd0);
    exp = {4'h7, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL srai: got %h want %h", got, exp); end
    issue_one(32'h00209233, 32'h108, 32'h0000000F, 32'h00000021);
    exp = {4'h2, 32'h0000000F, 32'd1, 5'd4, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sll_mask: got %h want %h", got, exp); end
    issue_one(32'hFFF00093, 32'h10C, 32'd0, 32'h12);
    exp = {4'h0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addi_neg: got %h want %h", got, exp); end
    issue_one(32'h12345137, 32'h110, 32'hDEADBEEF, 32'h1);
    exp = {4'h0, 32'd0, 32'h12345000, 5'd2, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lui: got %h want %h", got, exp); end
    issue_one(32'hABCDE397, 32'h00001000, 32'h55, 32'h66);
    exp = {4'h0, 32'h00001000, 32'hABCDE000, 5'd7, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL auipc: got %h want %h", got, exp); end
    issue_one(32'h00000000, 32'h118, 32'h11, 32'h22);
    exp = {4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL zero_word: got %h want %h", got, exp); end
    issue_one(32'h422081B3, 32'h11C, 32'h11, 32'h22);
    exp = {4'h0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bad_funct7: got %h want %h", got, exp); end
    issue_one(32'h00000013, 32'h120, 32'd0, 32'd0);
    exp = {4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addi_x0: got %h want %h", got, exp); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h00208533;
    bus.rs1_val   = 32'd10;
    bus.rs2_val   = 32'd1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.rd !== 5'd10)
      begin errors++; $display("FAIL b2b_first: got rdy=%b v=%b rd=%0d want 1 1 10", bus.in_ready, bus.out_valid, bus.rd); end
    bus.instr   = 32'h002085B3;
    bus.rs1_val = 32'd11;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.rd !== 5'd10)
      begin errors++; $display("FAIL b2b_full: got rdy=%b rd=%0d want 0 10", bus.in_ready, bus.rd); end
    bus.instr   = 32'h00208633;
    bus.rs1_val = 32'd12;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.rd !== 5'd10 || bus.alu_a !== 32'd10)
      begin errors++; $display("FAIL b2b_hold: got rdy=%b rd=%0d a=%0d want 0 10 10", bus.in_ready, bus.rd, bus.alu_a); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd !== 5'd11 || bus.alu_a !== 32'd11 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_second: got v=%b rd=%0d a=%0d rdy=%b want 1 11 11 1", bus.out_valid, bus.rd, bus.alu_a, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd !== 5'd12 || bus.alu_a !== 32'd12)
      begin errors++; $display("FAIL b2b_third: got v=%b rd=%0d a=%0d want 1 12 12", bus.out_valid, bus.rd, bus.alu_a); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got v=%b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_full;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h002081B3;
    bus.rs1_val   = 32'h77;
    bus.rs2_val   = 32'h88;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
      begin errors++; $display("FAIL rstfull_setup: got rdy=%b v=%b want 0 1", bus.in_ready, bus.out_valid); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== '0)
      begin errors++; $display("FAIL rstfull_clear: got v=%b rdy=%b out=%h want 0 1 0", bus.out_valid, bus.in_ready, got); end
  endtask

  task automatic test_random;
    issue_t      q[$];
    logic        pend;
    logic        acc, cons;
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [6:0]  f7;
    pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== (q.size() > 0))
        begin errors++; $display("FAIL rand_out_valid cyc %0d: got %b want %b", cyc, bus.out_valid, q.size() > 0); end
      checks++;
      if (bus.in_ready !== (q.size() < 2))
        begin errors++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, bus.in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++;
        if (got !== q[0]) begin errors++; $display("FAIL rand_data cyc %0d: got %h want %h", cyc, got, q[0]); end
      end
      if (!pend && $urandom_range(0, 9) < 7) begin
        ins = $urandom;
        case ($urandom_range(0, 9))
          0, 1, 2: opc = 7'h33;
          3, 4, 5: opc = 7'h13;
          6:       opc = 7'h37;
          7:       opc = 7'h17;
          default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0, 1:    f7 = 7'h00;
          2:       f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        ins[6:0] = opc;
        if (opc == 7'h33 || opc == 7'h13) ins[31:25] = f7;
        bus.instr   = ins;
        bus.pc      = $urandom;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        pend = 1'b1;
      end
      bus.in_valid  = pend;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      cons = (q.size() > 0) && bus.out_ready;
      acc  = pend && (q.size() < 2);
      if (cons) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_decode(bus.instr, bus.pc, bus.rs1_val, bus.rs2_val));
        pend = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      if (bus.out_valid === 1'b1) void'(q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL rand_drain: got left=%0d v=%b want 0 0", q.size(), bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
